// File: rtl/counter_arbiter.sv
// Round-robin sharing of one down-counter: IDLE grant -> LOAD -> RUN (until done/watchdog) -> DONE ack.
// Latency from grant sample: ack at V+2 (V>0), 2 (V==0), TMO+2 on timeout; no backpressure, ack is the only handshake.
module counter_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 3,
  parameter int TMO   = 12,
  localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int WDW  = $clog2(TMO + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] req_val,
  output logic [N_REQ-1:0]   ack,
  output logic               err,
  output logic               busy,
  output logic [IW-1:0]      grant_id,
  output logic               ctr_load,
  output logic [W-1:0]       ctr_count_to,
  output logic               ctr_count_en,
  input  logic               ctr_done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic [IW-1:0]    last_q, last_d;
  logic [W-1:0]     val_q, val_d;
  logic [WDW-1:0]   wdog_q, wdog_d, wdog_inc;
  logic             err_q, err_d;
  logic             load_q, load_d;
  logic             en_q, en_d;
  logic [N_REQ-1:0] ack_q, ack_d;

  logic [W-1:0]     val_arr [N_REQ];
  logic [IW-1:0]    pick, sel;
  logic             pick_vld;
  int               idx;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      val_arr[i] = req_val[i*W +: W];
    end
  end

  // Walk the offsets from farthest to nearest so the nearest requester above last_grant wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    sel      = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = int'(last_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      sel = IW'(idx);
      if (req[sel]) begin
        pick     = sel;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    val_d    = val_q;
    wdog_d   = wdog_q;
    wdog_inc = wdog_q + 1'b1;
    err_d    = 1'b0;
    load_d   = 1'b0;
    en_d     = 1'b0;
    ack_d    = '0;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_d = pick;
          val_d   = val_arr[pick];
          load_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        wdog_d = '0;
        if (val_q == '0) begin
          ack_d[grant_q] = 1'b1;
          state_d        = S_DONE;
        end else begin
          en_d    = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        wdog_d = wdog_inc;
        // A done arriving on the watchdog's last cycle still counts as a clean finish.
        if (ctr_done) begin
          ack_d[grant_q] = 1'b1;
          state_d        = S_DONE;
        end else if (wdog_inc == WDW'(TMO)) begin
          ack_d[grant_q] = 1'b1;
          err_d          = 1'b1;
          state_d        = S_DONE;
        end else begin
          en_d = 1'b1;
        end
      end
      S_DONE: begin
        last_d  = grant_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= IW'(N_REQ - 1);
      val_q   <= '0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
      en_q    <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      val_q   <= val_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
      load_q  <= load_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
    end
  end

  assign ack          = ack_q;
  assign err          = err_q;
  assign busy         = (state_q != S_IDLE);
  assign grant_id     = grant_q;
  assign ctr_load     = load_q;
  assign ctr_count_to = val_q;
  assign ctr_count_en = en_q;

endmodule

// File: doc/counter_arbiter.md
# counter_arbiter

Shares a single 3-bit down-counter (`load` / `count_to` / `count_en` / `done` interface) between several requesters, each asking for a timed interval of N counter ticks. A round-robin arbiter grants one requester at a time. A sequencing FSM then loads the counter, enables counting and waits for `done`. It returns a one-cycle acknowledge (or a timeout error) to the granted requester. The block sits between the requesting control blocks and the counter instance.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `W`, default 3: counter width; must match the counter's `count_to` width.
- `TMO`, default 12: watchdog limit in RUN cycles; must be ≥ 2^W + 2.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  level request per requester.
- `req_val`  in  N_REQ*W  requested count per requester; slice i is bits [i*W +: W].
- `ack`  out  N_REQ  one-cycle pulse when the granted interval completes.
- `err`  out  1  valid with `ack`: 1 means the interval ended by watchdog timeout.
- `busy`  out  1  high in every state except IDLE.
- `grant_id`  out  clog2(N_REQ)  index of the current or last granted requester.
- `ctr_load`  out  1  drives counter `load`.
- `ctr_count_to`  out  W  drives counter `count_to`; holds the latched value.
- `ctr_count_en`  out  1  drives counter `count_en`.
- `ctr_done`  in  1  counter `done`.

## Operation
- The FSM has four states: IDLE, LOAD, RUN and DONE.
- **IDLE**
  - If any `req` bit is set, the arbiter picks the first set bit, searching upward from `(last_grant+1) mod N_REQ` and wrapping.
  - It registers `grant_id` and latches that requester's `req_val` into `val_q`.
  - Next state is LOAD.
- **LOAD**
  - `ctr_load`=1 and `ctr_count_to`=`val_q`, for exactly one cycle.
  - If `val_q`==0, next state is DONE and RUN is skipped.
  - Otherwise next state is RUN.
- **RUN**
  - `ctr_count_en`=1.
  - The watchdog counter increments every RUN cycle.
  - When `ctr_done`=1, next state is DONE with `err_q`=0.
  - When the watchdog reaches `TMO`, next state is DONE with `err_q`=1.
  - If both happen in the same cycle, `ctr_done` wins and `err_q`=0.
- **DONE**
  - `ack[grant_id]`=1 and `err`=`err_q` for one cycle; `ctr_count_en`=0.
  - `last_grant` is updated to `grant_id`.
  - Next state is IDLE.
- **Request handling**
  - `ack` is the only handshake.
  - A requester that keeps `req` high after its `ack` is simply re-arbitrated; because the pointer has moved, it goes behind the other pending requesters.
  - Dropping `req` while granted does not abort the interval. `ack` is still issued.
  - `req_val` changes after the grant have no effect, because the value was latched in IDLE.
- **Outputs outside their states**
  - `ctr_load` and `ctr_count_en` are never high together and are 0 outside LOAD and RUN respectively.
  - `ack` is one-hot or zero, and `err`=0 whenever `ack`=0.
- **Width rules**
  - The watchdog is clog2(TMO+1) bits and is cleared on entry to RUN.
  - `val_q` is W bits with no arithmetic applied.

## Timing
- **Reset**
  - Asserting `reset_n`=0 immediately forces IDLE, whatever the current state.
  - During reset: `ack`=0, `err`=0, `busy`=0, `grant_id`=0, `ctr_load`=0, `ctr_count_to`=0, `ctr_count_en`=0, watchdog=0.
  - `last_grant` resets to N_REQ-1, so requester 0 has first priority after reset.
  - Reset asserted mid-RUN drops `ctr_count_en` asynchronously, and no `ack` is ever issued for the aborted interval.
- **Latency**, assuming the counter counts down one per enabled cycle and asserts `done` combinationally at count==0:
  - `req` is sampled in IDLE at cycle 0; LOAD is cycle 1.
  - For `val_q`=V>0, RUN spans cycles 2..V+1 and `ack` is high at cycle V+2.
  - For V=0, `ack` is high at cycle 2.
- **Throughput**: the next grant can be sampled in the IDLE cycle immediately after DONE. The minimum spacing between two grants is V+3 cycles.
- `busy` rises in the cycle after the grant decision (LOAD) and falls in the IDLE cycle that follows DONE.

## Test plan
- **Single request**
  - Stimulus: reset, then `req`=0001 with val[0]=7.
  - Required: `ctr_load` at cycle 1 with `ctr_count_to`=7; `ctr_count_en` high for 7 cycles; `ack`=0001 with `err`=0 at cycle 9.
- **Round robin**
  - Stimulus: `req`=1111 held with all vals=2.
  - Required: grant order 0,1,2,3,0; each `ack` is 5 cycles apart; no `ack` to a requester twice before all four have been served.
- **Zero value**
  - Stimulus: `req`=0100 with val[2]=0.
  - Required: LOAD then DONE; `ack`=0100 two cycles after the request is sampled; `ctr_count_en` never asserted.
- **Watchdog**
  - Stimulus: counter model with `ctr_done` tied to 0, `req`=0010 with val=5.
  - Required: after 12 RUN cycles, `ack`=0010 with `err`=1; the next interval runs normally with `err`=0.
- **Value latched at grant**
  - Stimulus: `req`=0001 with val=3; change val[0] to 6 in the LOAD cycle and drop `req` in the RUN cycle.
  - Required: `ctr_count_to`=3, 3 enabled cycles, `ack` still issued.
- **Reset mid-RUN**
  - Stimulus: while in RUN with val=6, assert `reset_n`=0 for 3 ns between clock edges.
  - Required: `ctr_count_en` and `busy` drop immediately; no `ack`; after release, `req`=1000 with val=1 is granted with `ack` at cycle 3.
